// File: rtl/picomem_mux_1_n.sv
// picomem_mux_1_n: registered 1:N PicoMem address decoder; unmapped or timed-out accesses get an error response.
// Optional error capture (err_addr/err_cause) is built when PICOMEM_MUX_ERRLOG_EN is defined.
module picomem_mux_1_n #(
    parameter int NUM_SLAVES = 8,
    parameter logic [32*NUM_SLAVES-1:0] ADDR_BASE = {32'h8700_0000, 32'h8600_0000, 32'h8500_0000, 32'h8400_0000,
                                                     32'h8300_0000, 32'h8200_0000, 32'h8100_0000, 32'h8000_0000},
    parameter logic [32*NUM_SLAVES-1:0] ADDR_MASK = {NUM_SLAVES{32'hFF00_0000}},
    parameter int TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic                     err_clr,
    output logic                     err_flag
`ifdef PICOMEM_MUX_ERRLOG_EN
    ,
    output logic [31:0]              err_addr,
    output logic [1:0]               err_cause
`endif
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;
    state_t state, state_n;
    logic [NUM_SLAVES-1:0] hit;
    logic [CW-1:0] cnt;
    logic [31:0] sel_rdata;
    logic rdy, tmo, err_evt;
    // Scan downwards so the lowest matching index is written last and wins.
    always_comb begin
        hit = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if (((m_addr ^ ADDR_BASE[32*i +: 32]) & ADDR_MASK[32*i +: 32]) == 32'd0)
                hit = NUM_SLAVES'(1) << i;
    end
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            sel_rdata |= s_valid[i] ? s_rdata[32*i +: 32] : 32'd0;
    end
    assign rdy = |(s_valid & s_ready);
    assign tmo = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign err_evt = state_n == ERR;
    assign m_ready = state == RESP || state == ERR;
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = !m_valid ? IDLE : |hit ? BUSY : ERR;
            BUSY: state_n = rdy ? RESP : tmo ? ERR : BUSY;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    // s_valid doubles as the latched one-hot select while BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid <= '0;
            s_addr <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
            m_rdata <= '0;
            cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == IDLE && m_valid) begin
                s_addr <= m_addr;
                s_wdata <= m_wdata;
                s_wstrb <= m_wstrb;
            end
            s_valid <= state_n != BUSY ? '0 : state == IDLE ? hit : s_valid;
            cnt <= state == BUSY ? cnt + 1'b1 : '0;
            if (err_evt)
                m_rdata <= ERR_RDATA;
            else if (state == BUSY && rdy)
                m_rdata <= sel_rdata;
            err_flag <= err_evt || (err_flag && !err_clr);
        end
    end
`ifdef PICOMEM_MUX_ERRLOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr <= '0;
            err_cause <= '0;
        end else if (err_evt && (!err_flag || err_clr)) begin
            err_addr <= state == IDLE ? m_addr : s_addr;
            err_cause <= state == IDLE ? 2'd1 : 2'd2;
        end else if (err_clr) begin
            err_addr <= '0;
            err_cause <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_picomem_mux_1_n.sv
// tb_picomem_mux_1_n: randomized self-checking bench; dut_a uses defaults, dut_b has TIMEOUT_CYCLES=4
// and slave 5 widened to 0x8xxx_xxxx so it overlaps slave 0.
module tb_picomem_mux_1_n;
    localparam logic [255:0] B_BASE = {32'h8700_0000, 32'h8600_0000, 32'h8000_0000, 32'h8400_0000,
                                       32'h8300_0000, 32'h8200_0000, 32'h8100_0000, 32'h8000_0000};
    localparam logic [255:0] B_MASK = {{2{32'hFF00_0000}}, 32'hF000_0000, {5{32'hFF00_0000}}};
    logic clk = 1'b0;
    logic reset = 1'b1, m_valid = 1'b0, err_clr = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0] m_wstrb = '0;
    logic [7:0] s_ready = '0;
    logic [255:0] s_rdata = '0;
    logic a_m_ready, b_m_ready, a_err_flag, b_err_flag;
    logic [31:0] a_m_rdata, b_m_rdata, a_s_addr, b_s_addr, a_s_wdata, b_s_wdata;
    logic [7:0] a_s_valid, b_s_valid;
    logic [3:0] a_s_wstrb, b_s_wstrb;
`ifdef PICOMEM_MUX_ERRLOG_EN
    logic [31:0] a_err_addr, b_err_addr;
    logic [1:0] a_err_cause, b_err_cause;
`endif
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    picomem_mux_1_n dut_a (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_ready(a_m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(a_m_rdata), .s_valid(a_s_valid),
        .s_ready(s_ready), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
        .s_rdata(s_rdata), .err_clr(err_clr), .err_flag(a_err_flag)
`ifdef PICOMEM_MUX_ERRLOG_EN
        , .err_addr(a_err_addr), .err_cause(a_err_cause)
`endif
    );

    picomem_mux_1_n #(.ADDR_BASE(B_BASE), .ADDR_MASK(B_MASK), .TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_ready(b_m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(b_m_rdata), .s_valid(b_s_valid),
        .s_ready(s_ready), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
        .s_rdata(s_rdata), .err_clr(err_clr), .err_flag(b_err_flag)
`ifdef PICOMEM_MUX_ERRLOG_EN
        , .err_addr(b_err_addr), .err_cause(b_err_cause)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; m_valid = 1'b0; s_ready = '0; err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one access, plays slave tgt (ready from cycle delay+1) and records what the selected DUT did.
    task automatic run_txn(input bit b, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int tgt, input int delay, input logic [31:0] rd, input int ncyc,
                           output int sv_cycles, output logic [7:0] sv_seen, output int lat,
                           output logic [31:0] rdata, output int pulses, output bit hold_ok);
        logic [7:0] sv;
        sv_cycles = 0; sv_seen = '0; lat = -1; rdata = '0; pulses = 0; hold_ok = 1'b1;
        @(negedge clk);
        m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb; s_ready = '0;
        @(negedge clk);
        m_valid = 1'b0; m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom);
        for (int c = 1; c <= ncyc; c++) begin
            sv = b ? b_s_valid : a_s_valid;
            if (sv != 0) begin
                sv_cycles++;
                sv_seen |= sv;
                if ((b ? b_s_wdata : a_s_wdata) !== wdata || (b ? b_s_addr : a_s_addr) !== addr) hold_ok = 1'b0;
            end
            if ((b ? b_m_ready : a_m_ready) === 1'b1) begin
                pulses++;
                if (lat < 0) begin lat = c; rdata = b ? b_m_rdata : a_m_rdata; end
            end
            s_ready = 8'($urandom);
            for (int i = 0; i < 8; i++) s_rdata[32*i +: 32] = $urandom;
            if (tgt >= 0) begin
                s_ready[tgt] = c >= delay + 1;
                s_rdata[32*tgt +: 32] = rd;
            end
            @(negedge clk);
        end
        s_ready = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; m_valid = 1'b1; m_addr = 32'h8100_0000; s_ready = '1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_m_ready !== 1'b0) begin errors++; $display("FAIL reset_m_ready got %b want 0", a_m_ready); end
        checks++; if (a_s_valid !== 8'h00) begin errors++; $display("FAIL reset_s_valid got %h want 00", a_s_valid); end
        checks++; if (a_m_rdata !== 32'h0) begin errors++; $display("FAIL reset_m_rdata got %h want 0", a_m_rdata); end
        checks++; if ({a_s_addr, a_s_wdata, a_s_wstrb} !== 68'h0) begin errors++; $display("FAIL reset_s_bus got %h/%h/%h want 0", a_s_addr, a_s_wdata, a_s_wstrb); end
        checks++; if (a_err_flag !== 1'b0) begin errors++; $display("FAIL reset_err_flag got %b want 0", a_err_flag); end
`ifdef PICOMEM_MUX_ERRLOG_EN
        checks++; if ({a_err_addr, a_err_cause} !== 34'h0) begin errors++; $display("FAIL reset_errlog got %h/%0d want 0", a_err_addr, a_err_cause); end
`endif
        m_valid = 1'b0; s_ready = '0;
        reset = 1'b0;
    endtask

    task automatic test_read();
        int svc, lat, pul; logic [7:0] seen; logic [31:0] rd; bit ok;
        do_reset();
        run_txn(0, 32'h8200_0010, 32'h0, 4'b0000, 2, 0, 32'h1234_5678, 6, svc, seen, lat, rd, pul, ok);
        checks++; if (seen !== 8'b0000_0100 || svc != 1) begin errors++; $display("FAIL read_s_valid got %b x%0d want 00000100 x1", seen, svc); end
        checks++; if (lat != 2 || pul != 1) begin errors++; $display("FAIL read_m_ready got cycle %0d x%0d want cycle 2 x1", lat, pul); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL read_rdata got %h want 12345678", rd); end
        checks++; if (a_err_flag !== 1'b0) begin errors++; $display("FAIL read_err_flag got %b want 0", a_err_flag); end
    endtask

    task automatic test_write();
        int svc, lat, pul; logic [7:0] seen; logic [31:0] rd; bit ok;
        do_reset();
        run_txn(0, 32'h8300_0004, 32'hA5, 4'b0001, 3, 5, 32'h0, 12, svc, seen, lat, rd, pul, ok);
        checks++; if (seen !== 8'b0000_1000 || svc != 6) begin errors++; $display("FAIL write_s_valid got %b x%0d want 00001000 x6", seen, svc); end
        checks++; if (!ok) begin errors++; $display("FAIL write_hold got unstable s_addr/s_wdata want stable"); end
        checks++; if (pul != 1 || lat != 7) begin errors++; $display("FAIL write_m_ready got cycle %0d x%0d want cycle 7 x1", lat, pul); end
        checks++; if (a_s_wstrb !== 4'b0001 || a_s_wdata !== 32'hA5) begin errors++; $display("FAIL write_held got %b/%h want 0001/a5", a_s_wstrb, a_s_wdata); end
    endtask

    task automatic test_unmapped();
        int svc, lat, pul; logic [7:0] seen; logic [31:0] rd; bit ok;
        do_reset();
        run_txn(0, 32'h9000_0000, 32'h0, 4'b0000, -1, 0, 32'h0, 4, svc, seen, lat, rd, pul, ok);
        checks++; if (svc != 0) begin errors++; $display("FAIL unmapped_s_valid got %0d cycles want 0", svc); end
        checks++; if (lat != 1 || pul != 1) begin errors++; $display("FAIL unmapped_m_ready got cycle %0d x%0d want cycle 1 x1", lat, pul); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unmapped_rdata got %h want deadbeef", rd); end
        checks++; if (a_err_flag !== 1'b1) begin errors++; $display("FAIL unmapped_err_flag got %b want 1", a_err_flag); end
        run_txn(0, 32'h9100_0000, 32'h0, 4'b0000, -1, 0, 32'h0, 3, svc, seen, lat, rd, pul, ok);
`ifdef PICOMEM_MUX_ERRLOG_EN
        checks++; if (a_err_addr !== 32'h9000_0000 || a_err_cause !== 2'd1) begin errors++; $display("FAIL unmapped_errlog got %h/%0d want 90000000/1", a_err_addr, a_err_cause); end
`endif
        checks++; if (a_err_flag !== 1'b1) begin errors++; $display("FAIL unmapped2_err_flag got %b want 1", a_err_flag); end
    endtask

    task automatic test_timeout();
        int svc, lat, pul; logic [7:0] seen; logic [31:0] rd; bit ok;
        do_reset();
        run_txn(1, 32'h8000_0040, 32'h0, 4'b0000, 0, 1000, 32'h0, 8, svc, seen, lat, rd, pul, ok);
        checks++; if (seen !== 8'b0000_0001 || svc != 4) begin errors++; $display("FAIL timeout_s_valid got %b x%0d want 00000001 x4", seen, svc); end
        checks++; if (lat != 5 || pul != 1 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL timeout_resp got cycle %0d x%0d %h want cycle 5 x1 deadbeef", lat, pul, rd); end
        checks++; if (b_err_flag !== 1'b1) begin errors++; $display("FAIL timeout_err_flag got %b want 1", b_err_flag); end
`ifdef PICOMEM_MUX_ERRLOG_EN
        checks++; if (b_err_addr !== 32'h8000_0040 || b_err_cause !== 2'd2) begin errors++; $display("FAIL timeout_errlog got %h/%0d want 80000040/2", b_err_addr, b_err_cause); end
`endif
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (b_err_flag !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", b_err_flag); end
`ifdef PICOMEM_MUX_ERRLOG_EN
        checks++; if ({b_err_addr, b_err_cause} !== 34'h0) begin errors++; $display("FAIL err_clr_log got %h/%0d want 0", b_err_addr, b_err_cause); end
`endif
        m_valid = 1'b1; m_addr = 32'h9000_0000; err_clr = 1'b1;
        @(negedge clk);
        m_valid = 1'b0; err_clr = 1'b0;
        checks++; if (b_err_flag !== 1'b1 || b_m_ready !== 1'b1) begin errors++; $display("FAIL set_wins got flag %b ready %b want 1 1", b_err_flag, b_m_ready); end
    endtask

    task automatic test_overlap();
        int svc, lat, pul; logic [7:0] seen; logic [31:0] rd; bit ok;
        do_reset();
        run_txn(1, 32'h8000_0000, 32'h0, 4'b0000, 0, 0, 32'h0BAD_F00D, 5, svc, seen, lat, rd, pul, ok);
        checks++; if (seen !== 8'b0000_0001 || rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL overlap_low got %b %h want 00000001 0badf00d", seen, rd); end
        run_txn(1, 32'h8A00_0000, 32'h0, 4'b0000, 5, 1, 32'h5555_AAAA, 6, svc, seen, lat, rd, pul, ok);
        checks++; if (seen !== 8'b0010_0000 || rd !== 32'h5555_AAAA || lat != 3) begin errors++; $display("FAIL overlap_wide got %b %h cycle %0d want 00100000 5555aaaa cycle 3", seen, rd, lat); end
    endtask

    task automatic test_reset_busy();
        int svc, lat, pul, n; logic [7:0] seen; logic [31:0] rd; bit ok;
        do_reset();
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h8200_0000; s_ready = '0;
        @(negedge clk);
        m_valid = 1'b0;
        checks++; if (a_s_valid !== 8'b0000_0100) begin errors++; $display("FAIL rbusy_pre got %b want 00000100", a_s_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (a_s_valid !== 8'h00 || a_m_ready !== 1'b0) begin errors++; $display("FAIL rbusy_abort got %b ready %b want 0 0", a_s_valid, a_m_ready); end
        n = 0;
        for (int c = 0; c < 4; c++) begin
            s_ready = 8'($urandom);
            @(negedge clk);
            if (a_m_ready === 1'b1) n++;
        end
        s_ready = '0;
        checks++; if (n != 0) begin errors++; $display("FAIL rbusy_no_resp got %0d pulses want 0", n); end
        run_txn(0, 32'h8100_0000, 32'h0, 4'b0000, 1, 1, 32'h7777_0001, 6, svc, seen, lat, rd, pul, ok);
        checks++; if (lat != 3 || rd !== 32'h7777_0001 || seen !== 8'b0000_0010) begin errors++; $display("FAIL rbusy_after got cycle %0d %h %b want cycle 3 77770001 00000010", lat, rd, seen); end
    endtask

    task automatic test_back_to_back();
        int pul, first, exp_pul;
        do_reset();
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h8400_0000; s_ready = 8'h10; s_rdata[32*4 +: 32] = 32'hCAFE_0004;
        @(negedge clk);
        pul = 0; first = -1; exp_pul = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c >= 2 && (c - 2) % 3 == 0) exp_pul++;
            if (a_m_ready === 1'b1) begin pul++; if (first < 0) first = c; end
            @(negedge clk);
        end
        m_valid = 1'b0; s_ready = '0;
        checks++; if (pul != exp_pul || first != 2) begin errors++; $display("FAIL b2b got %0d pulses first %0d want %0d first 2", pul, first, exp_pul); end
        checks++; if (a_m_rdata !== 32'hCAFE_0004) begin errors++; $display("FAIL b2b_rdata got %h want cafe0004", a_m_rdata); end
    endtask

    task automatic test_random();
        int svc, lat, pul, r, tgt, d; logic [7:0] seen, top; logic [31:0] rd, addr, rdv; bit ok, model_err;
        do_reset();
        model_err = 1'b0;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            top = r < 8 ? 8'(8'h80 + r) : r == 8 ? 8'($urandom_range(0, 127)) : 8'($urandom_range(136, 255));
            addr = {top, 24'($urandom)};
            tgt = (top >= 8'h80 && top <= 8'h87) ? int'(top) - 8'h80 : -1;
            d = $urandom_range(0, 6);
            rdv = $urandom;
            run_txn(0, addr, $urandom, 4'($urandom), tgt, d, rdv, tgt >= 0 ? d + 4 : 3, svc, seen, lat, rd, pul, ok);
            if (tgt < 0) model_err = 1'b1;
            if (tgt >= 0) begin
                checks++; if (seen !== 8'(1 << tgt) || svc != d + 1 || !ok) begin errors++; $display("FAIL rand%0d_sel addr %h got %b x%0d want %b x%0d", t, addr, seen, svc, 8'(1 << tgt), d + 1); end
                checks++; if (lat != d + 2 || pul != 1 || rd !== rdv) begin errors++; $display("FAIL rand%0d_resp got cycle %0d x%0d %h want cycle %0d x1 %h", t, lat, pul, rd, d + 2, rdv); end
            end else begin
                checks++; if (svc != 0 || lat != 1 || pul != 1 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rand%0d_err addr %h got sv %0d cycle %0d x%0d %h want 0 1 x1 deadbeef", t, addr, svc, lat, pul, rd); end
            end
            checks++; if (a_err_flag !== model_err) begin errors++; $display("FAIL rand%0d_flag got %b want %b", t, a_err_flag, model_err); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_overlap();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
